fifo_write_arbiter: RTL

Round-robin arbiter that shares the single write port of a stream FIFO between NUM_REQ valid/ready requesters. It grants one requester at a time for a burst. The burst ends on that requester's last-flagged beat or after MAX_BURST beats, whichever comes first. It sits between producer blocks and the FIFO's in_data/in_valid/in_ready port, and is pure control plus a registered grant with no data storage.

---
 rtl/fifo_write_arbiter_if.sv | 25 ++
 rtl/fifo_write_arbiter.sv | 94 +++++++++
 2 files changed

// File: rtl/fifo_write_arbiter_if.sv
// Write-port bundle between NUM_REQ producers, the arbiter and a stream FIFO.
interface fifo_write_arbiter_if #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned DATA_BIT_WIDTH = 32
);
    logic [NUM_REQ*DATA_BIT_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]                req_valid;
    logic [NUM_REQ-1:0]                req_last;
    logic [NUM_REQ-1:0]                req_ready;
    logic [DATA_BIT_WIDTH-1:0]         fifo_data;
    logic                              fifo_valid;
    logic                              fifo_ready;

    // Arbiter side
    modport master (
        input  req_data, req_valid, req_last, fifo_ready,
        output req_ready, fifo_data, fifo_valid
    );

    // Producer/FIFO side
    modport slave (
        output req_data, req_valid, req_last, fifo_ready,
        input  req_ready, fifo_data, fifo_valid
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
// Control only: the grantee's beat is passed straight through to the FIFO.
module fifo_write_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned DATA_BIT_WIDTH = 32,
    parameter int unsigned MAX_BURST      = 8,
    parameter int unsigned ID_BIT_WIDTH   = $clog2(NUM_REQ),
    parameter int unsigned CNT_BIT_WIDTH  = $clog2(MAX_BURST + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    fifo_write_arbiter_if.master     bus,
    output logic                     grant_active,
    output logic [ID_BIT_WIDTH-1:0]  grant_id,
    output logic [CNT_BIT_WIDTH-1:0] beat_count
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                    state;
    logic [ID_BIT_WIDTH-1:0]   last_id;
    logic [ID_BIT_WIDTH-1:0]   choice;
    logic [ID_BIT_WIDTH-1:0]   cand;
    logic                      found;
    logic                      accept;
    logic                      release_grant;
    logic [DATA_BIT_WIDTH-1:0] slice [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign slice[i] = bus.req_data[i*DATA_BIT_WIDTH +: DATA_BIT_WIDTH];
    end

    // First valid requester after the previous grantee, wrapping around
    always_comb begin
        choice = last_id;
        cand   = '0;
        found  = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = ID_BIT_WIDTH'((32'(last_id) + k) % NUM_REQ);
            if (!found && bus.req_valid[cand]) begin
                choice = cand;
                found  = 1'b1;
            end
        end
    end

    assign grant_active  = (state == GRANT);
    assign accept        = grant_active && bus.req_valid[grant_id] && bus.fifo_ready;
    assign release_grant = accept &&
                           (bus.req_last[grant_id] ||
                            (beat_count == CNT_BIT_WIDTH'(MAX_BURST - 1)));

    // fifo_ready only steers req_ready, never fifo_valid
    always_comb begin
        bus.req_ready  = '0;
        bus.fifo_valid = 1'b0;
        bus.fifo_data  = '0;
        if (grant_active) begin
            bus.fifo_valid          = bus.req_valid[grant_id];
            bus.fifo_data           = slice[grant_id];
            bus.req_ready[grant_id] = bus.fifo_ready;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_id    <= ID_BIT_WIDTH'(NUM_REQ - 1);
            beat_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req_valid) begin
                        grant_id   <= choice;
                        beat_count <= '0;
                        state      <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_grant) begin
                        last_id    <= grant_id;
                        beat_count <= '0;
                        state      <= IDLE;
                    end else if (accept) begin
                        beat_count <= beat_count + CNT_BIT_WIDTH'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
